muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multi-cycle execution unit for the RV32M multiply/divide group. It sits beside the single-cycle ALU in the execute stage.
- The main decoder raises start for OP-type instructions with funct7 = 0000001. The unit stalls the core via busy, then presents a 32-bit result with a one-cycle done pulse.
- It sequences a radix-2 shift-add multiplier and a restoring divider over one shared XLEN-bit adder and shift datapath.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- flush  input  1  synchronous abort (pipeline redirect); returns to IDLE with no done.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value; captured on accepted start.
- op_b  input  XLEN  rs2 value; captured on accepted start.
- busy  output  1  high from the cycle after accept through the DONE cycle inclusive; core stalls PC/regfile write while busy & !done.
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  XLEN  final value; held stable until the next accepted start.

Behaviour:
- Reset (rst_n low, async): state = IDLE; busy = 0, done = 0, result = 0; counter and internal registers = 0. Reset mid-operation discards the operation; no done follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start & !flush accepts the request. Latch funct3, |op_a|, |op_b| and the sign flags.
  - Signedness per op:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MUL, MULHU, DIVU, REMU: treated as unsigned.
  - Fast path, checked at accept: a divide op with op_b = 0, or DIV/REM with op_a = 0x80000000 and op_b = 0xFFFFFFFF, goes directly to DONE with the spec result (below).
  - All other accepted ops go to CALC with counter = 0.
- CALC, one iteration per cycle, XLEN cycles (counter 0..XLEN-1):
  - Multiply: 2*XLEN product register. If the multiplier LSB = 1, add the multiplicand into the upper half (XLEN+1-bit carry kept), then shift right 1.
  - Divide: shift the {rem, quot} register left 1, trial-subtract the divisor from rem. If there is no borrow, commit the difference and set quot LSB = 1.
  - Counter = XLEN-1 goes to FIX.
- FIX, 1 cycle: apply sign correction (two's-complement negate).
  - Product negated if the operand signs differ, over the full 2*XLEN bits.
  - Quotient negated if sa ^ sb; remainder negated if sa.
  - Select the result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder. Go to DONE.
- DONE, 1 cycle: done = 1, busy = 1, result register updated, return to IDLE. A start seen in DONE is ignored; the core re-issues the next instruction after unstall.
- Latency:
  - Normal ops: accept at cycle 0, done at cycle XLEN+2 (34 for XLEN = 32).
  - Fast path: done at cycle 1.
- Spec results:
  - x / 0: DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow: DIV gives 0x80000000, REM gives 0.
- start while busy: ignored, with no effect on the in-flight operation.
- flush:
  - In any non-IDLE state, go to IDLE next cycle with busy = 0 and done = 0; result keeps its previous value.
  - flush & start in IDLE: start is dropped.
  - flush in DONE: done is still asserted that cycle (combinational from state); the state returns to IDLE as normal.
- Operand changes after accept have no effect.

Test Plan:
- MUL op_a = 7, op_b = 0xFFFFFFFD: busy rises cycle 1; done at cycle 34 with result = 0xFFFFFFEB; result holds until the next start.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; each done at cycle 34.
- Divide by zero and overflow:
  - DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; each done at cycle 1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; each done at cycle 1.
- start pulsed again at cycle 10 with different operands and funct3: ignored; done at cycle 34 with the original op's result.
- Interrupts:
  - rst_n low at cycle 15: busy = 0, done = 0, result = 0 immediately (async).
  - flush at cycle 15 of a fresh op: IDLE at cycle 16, no done ever, result unchanged.
  - A new start after either is accepted normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply and restoring
// divide share one adder and one 2*XLEN shift register. Sign fix-up happens in a final FIX cycle.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Request decode, evaluated on the raw inputs for the accept cycle.
    logic            in_div, in_sa, in_sb, sign_a, sign_b, in_div_zero, in_div_ovf;
    logic [XLEN-1:0] abs_a, abs_b;

    always_comb begin
        in_div      = funct3[2];
        in_sa       = in_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        in_sb       = in_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        sign_a      = in_sa & op_a[XLEN-1];
        sign_b      = in_sb & op_b[XLEN-1];
        abs_a       = sign_a ? -op_a : op_a;
        abs_b       = sign_b ? -op_b : op_b;
        in_div_zero = in_div && (op_b == '0);
        in_div_ovf  = in_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    end

    // Shared datapath: acc holds {product hi, multiplier} or {remainder, quotient}.
    logic [XLEN-1:0]   acc_hi, acc_lo;
    logic [XLEN:0]     add_a, add_b;
    logic              add_ci;
    logic [XLEN+1:0]   add_sum;
    logic [2*XLEN-1:0] calc_next;

    assign acc_hi = acc_q[2*XLEN-1:XLEN];
    assign acc_lo = acc_q[XLEN-1:0];

    always_comb begin
        if (funct3_q[2]) begin
            // Trial subtract of the divisor from the left-shifted remainder.
            add_a  = {acc_hi, acc_lo[XLEN-1]};
            add_b  = ~{1'b0, opnd_q};
            add_ci = 1'b1;
        end else begin
            add_a  = {1'b0, acc_hi};
            add_b  = {1'b0, opnd_q};
            add_ci = 1'b0;
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_ci};

        if (funct3_q[2]) begin
            if (add_sum[XLEN+1])
                calc_next = {add_sum[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
            else
                calc_next = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            if (acc_lo[0])
                calc_next = {add_sum[XLEN:0], acc_lo[XLEN-1:1]};
            else
                calc_next = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    // Sign correction and result select for the FIX cycle.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot_fix = (sa_q ^ sb_q) ? -acc_lo : acc_lo;
        rem_fix  = sa_q ? -acc_hi : acc_hi;
        case (funct3_q)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    funct3_d = funct3;
                    sa_d     = sign_a;
                    sb_d     = sign_b;
                    cnt_d    = '0;
                    if (in_div) begin
                        opnd_d = abs_b;
                        acc_d  = {{XLEN{1'b0}}, abs_a};
                    end else begin
                        opnd_d = abs_a;
                        acc_d  = {{XLEN{1'b0}}, abs_b};
                    end
                    if (in_div_zero) begin
                        state_d  = DONE;
                        result_d = funct3[1] ? op_a : '1;
                    end else if (in_div_ovf) begin
                        state_d  = DONE;
                        result_d = funct3[1] ? '0 : MIN_NEG;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = calc_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST)
                    state_d = FIX;
            end
            FIX: begin
                result_d = fix_result;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Abort keeps the previously delivered result visible to the core.
        if (flush && state_q != IDLE) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale state behind.
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: results, latencies, fast paths,
// ignored restart, async reset and flush aborts.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    muldiv_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Accept edge: call #1 after a posedge with the unit idle; returns #1 into cycle 1.
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        @(posedge clk); #1;
        start  = 1'b0;
        funct3 = F_REMU;
        op_a   = 32'h1234_5678;
        op_b   = 32'h0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input bit poke, input bit flush_in_done);
        int lat;
        launch(f3, a, b);
        check({tag, "_busy_c1"}, {31'b0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 60) begin
            if (poke && lat == 10) begin
                start  = 1'b1;
                funct3 = F_DIVU;
                op_a   = 32'd1000;
                op_b   = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
        if (flush_in_done) begin
            flush = 1'b1;
            #1;
            check({tag, "_done_under_flush"}, {31'b0, done}, 32'd1);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        check({tag, "_idle_after"}, {30'b0, busy, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold"}, result, exp);
    endtask

    task automatic watch_no_done(input string tag);
        int seen;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {busy, done, result[29:0]}, 32'd0);
        check("reset_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiply variants
        do_op("mul",     F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0, 1'b0);
        do_op("mul_m1",  F_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, 1'b0, 1'b0);
        do_op("mulh",    F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0, 1'b0);
        do_op("mulhu",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0, 1'b0);
        do_op("mulhsu",  F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0, 1'b0);

        // Divide variants
        do_op("div",     F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b0, 1'b0);
        do_op("rem",     F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b0, 1'b0);
        do_op("div_nb",  F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0, 1'b0);
        do_op("rem_nb",  F_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34, 1'b0, 1'b0);
        do_op("divu",    F_DIVU,   32'd100,       32'd7,         32'd14,        34, 1'b0, 1'b0);
        do_op("remu",    F_REMU,   32'd100,       32'd7,         32'd2,         34, 1'b0, 1'b0);

        // Fast paths
        do_op("divu_z",  F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        do_op("rem_z",   F_REM,    32'd5,         32'd0,         32'd5,         1, 1'b0, 1'b0);
        do_op("div_ovf", F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b0);
        do_op("rem_ovf", F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0, 1'b0);

        // Restart while busy is ignored; flush during DONE still delivers
        do_op("mul_poke", F_MUL,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1, 1'b0);
        do_op("remu_fd",  F_REMU,  32'd100,       32'd7,         32'd2,         34, 1'b0, 1'b1);

        // Async reset mid-operation
        launch(F_DIVU, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy_done", {30'b0, busy, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        watch_no_done("rst_mid_no_done");
        do_op("after_rst", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0, 1'b0);

        // Flush mid-operation
        launch(F_DIVU, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle_c16", {30'b0, busy, done}, 32'd0);
        watch_no_done("flush_no_done");
        check("flush_result_kept", result, 32'hFFFF_FFFE);

        // Flush together with start in IDLE drops the start
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = F_MUL;
        op_a   = 32'd3;
        op_b   = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_dropped", {30'b0, busy, done}, 32'd0);
        do_op("after_flush", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
